// File: rtl/dma_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_pkg
// Shared definitions for the DMA bus arbiter:
//   - arb_state_t : 3-bit FSM state encoding (ARB_IDLE .. ARB_GRANT)
//   - default DMA command address/length and the grant watchdog limit
// -----------------------------------------------------------------------------
package dma_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE       = 3'd0,
    ARB_CMD        = 3'd1,
    ARB_WAIT_BR    = 3'd2,
    ARB_WAIT_CACHE = 3'd3,
    ARB_GRANT      = 3'd4
  } arb_state_t;

  localparam logic [15:0] DMA_BASE_ADDR_DEFAULT = 16'h01F4;
  localparam logic [15:0] DMA_LEN_DEFAULT       = 16'd12;
  localparam logic [4:0]  MAX_GRANT_DEFAULT     = 5'd16;

endpackage

// File: rtl/dma_bus_arbiter_grant_watchdog.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_grant_watchdog
// Counts consecutive granted cycles in which the Dcache is also asking for the
// bus and raises preempt once the count reaches MAX_GRANT. preempt then stays
// high until the DMA drops BR (or the grant ends).
// Only present when BUS_PREEMPT_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   granted      : BG is currently high
//   cpu_mem_req  : Dcache wants the bus this cycle
//   br           : DMA bus request level
//   preempt      : registered request to release the bus
// -----------------------------------------------------------------------------
`ifdef BUS_PREEMPT_EN
module dma_bus_arbiter_grant_watchdog
  import dma_bus_arbiter_pkg::*;
#(
  parameter logic [4:0] MAX_GRANT = MAX_GRANT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic granted,
  input  logic cpu_mem_req,
  input  logic br,
  output logic preempt
);

  logic [4:0] grant_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= 5'd0;
      preempt   <= 1'b0;
    end else begin
      // Counter saturates at MAX_GRANT; any cycle without contention clears it.
      if (granted && cpu_mem_req) begin
        if (grant_cnt != MAX_GRANT) grant_cnt <= grant_cnt + 5'd1;
      end else begin
        grant_cnt <= 5'd0;
      end
      // preempt rises on the edge where the count lands on MAX_GRANT and is
      // released only when the DMA gives the bus back.
      if (!granted || !br)
        preempt <= 1'b0;
      else if (cpu_mem_req && (grant_cnt == MAX_GRANT - 5'd1))
        preempt <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
// Issues a DMA command on an external-device interrupt and then shares the
// data-memory bus between the Dcache and the DMA controller via BR/BG.
// Optional feature macro: BUS_PREEMPT_EN (grant watchdog + preempt output).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   dma_start_int       : pulse, request a transfer (1-deep pending if busy)
//   dma_end_int         : pulse, DMA transfer complete
//   BR                  : DMA bus request (level)
//   cache_memory_access : Dcache transaction in flight (level)
//   cpu_mem_req         : Dcache wants the bus this cycle
//   cmd/cmd_addr/cmd_len: one-cycle DMA command; addr/len are 0 when cmd=0
//   BG                  : registered bus grant to DMA
//   cpu_stall           : cpu_mem_req & BG
//   dma_busy            : FSM not idle
//   preempt             : ask DMA to release the bus (0 without the feature)
//   dbg_state           : current FSM state
//
// Handshake: BR is a level held by the DMA for as long as it wants the bus.
// BG rises on the edge after BR is seen high with no Dcache access in flight
// and stays high until the edge after BR is seen low. The Dcache is never cut
// off mid-access because the grant decision samples cache_memory_access=0.
// -----------------------------------------------------------------------------
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_BASE_ADDR = DMA_BASE_ADDR_DEFAULT,
  parameter logic [15:0] DMA_LEN       = DMA_LEN_DEFAULT,
  parameter logic [4:0]  MAX_GRANT     = MAX_GRANT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_start_int,
  input  logic        dma_end_int,
  input  logic        BR,
  input  logic        cache_memory_access,
  input  logic        cpu_mem_req,
  output logic        cmd,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_len,
  output logic        BG,
  output logic        cpu_stall,
  output logic        dma_busy,
  output logic        preempt,
  output logic [2:0]  dbg_state
);

  arb_state_t state;
  logic       pending;
  logic       done;
  logic       hold_off;

`ifdef BUS_PREEMPT_EN
  logic defer_br;

  dma_bus_arbiter_grant_watchdog #(
    .MAX_GRANT (MAX_GRANT)
  ) u_grant_watchdog (
    .clk         (clk),
    .reset       (reset),
    .granted     (BG),
    .cpu_mem_req (cpu_mem_req),
    .br          (BR),
    .preempt     (preempt)
  );

  // Right after a preempted release, a BR that collides with a Dcache request
  // waits one cycle so the Dcache gets the bus at least once.
  assign hold_off = defer_br & cpu_mem_req;
`else
  logic unused_max_grant;
  assign unused_max_grant = ^MAX_GRANT;
  assign preempt          = 1'b0;
  assign hold_off         = 1'b0;
`endif

  assign cpu_stall = cpu_mem_req & BG;
  assign dma_busy  = (state != ARB_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      cmd      <= 1'b0;
      cmd_addr <= 16'd0;
      cmd_len  <= 16'd0;
      BG       <= 1'b0;
      pending  <= 1'b0;
      done     <= 1'b0;
`ifdef BUS_PREEMPT_EN
      defer_br <= 1'b0;
`endif
    end else begin
      cmd      <= 1'b0;
      cmd_addr <= 16'd0;
      cmd_len  <= 16'd0;
`ifdef BUS_PREEMPT_EN
      defer_br <= 1'b0;
`endif
      // A start while busy is remembered once; extra starts are dropped.
      if ((state != ARB_IDLE) && dma_start_int) pending <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (pending || dma_start_int) begin
            state    <= ARB_CMD;
            cmd      <= 1'b1;
            cmd_addr <= DMA_BASE_ADDR;
            cmd_len  <= DMA_LEN;
            pending  <= 1'b0;
          end
        end
        ARB_CMD: state <= ARB_WAIT_BR;
        ARB_WAIT_BR: begin
          if (BR && !hold_off) begin
            if (cache_memory_access) begin
              state <= ARB_WAIT_CACHE;
            end else begin
              state <= ARB_GRANT;
              BG    <= 1'b1;
            end
          end else if (!BR && dma_end_int) begin
            state <= ARB_IDLE;
          end
        end
        ARB_WAIT_CACHE: begin
          if (!BR) begin
            state <= ARB_WAIT_BR;
          end else if (!cache_memory_access) begin
            state <= ARB_GRANT;
            BG    <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (dma_end_int) done <= 1'b1;
          if (!BR) begin
            BG    <= 1'b0;
            done  <= 1'b0;
            // End pulse in the same cycle as the BR fall still counts as done.
            state <= (done || dma_end_int) ? ARB_IDLE : ARB_WAIT_BR;
`ifdef BUS_PREEMPT_EN
            defer_br <= preempt;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_arbiter
// Directed scenarios for the DMA bus arbiter followed by a randomized run
// checked against a transfer-level reference model. Define BUS_PREEMPT_EN to
// also exercise the grant watchdog.
// -----------------------------------------------------------------------------
module tb_dma_bus_arbiter;
  import dma_bus_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        dma_start_int, dma_end_int, BR, cache_memory_access, cpu_mem_req;
  logic        cmd, BG, cpu_stall, dma_busy, preempt;
  logic [15:0] cmd_addr, cmd_len;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  dma_bus_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .dma_start_int       (dma_start_int),
    .dma_end_int         (dma_end_int),
    .BR                  (BR),
    .cache_memory_access (cache_memory_access),
    .cpu_mem_req         (cpu_mem_req),
    .cmd                 (cmd),
    .cmd_addr            (cmd_addr),
    .cmd_len             (cmd_len),
    .BG                  (BG),
    .cpu_stall           (cpu_stall),
    .dma_busy            (dma_busy),
    .preempt             (preempt),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic en, input logic br,
                       input logic cma, input logic req);
    dma_start_int       = st;
    dma_end_int         = en;
    BR                  = br;
    cache_memory_access = cma;
    cpu_mem_req         = req;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transfer level) ----------------
  // busy: a transfer has been commanded and not completed
  // in_cmd: the command cycle is being presented
  // owns_bus: DMA holds the grant; blocked: DMA asked while cache was busy
  bit m_busy, m_in_cmd, m_owns_bus, m_blocked, m_done, m_pend;

  task automatic model_reset();
    m_busy = 0; m_in_cmd = 0; m_owns_bus = 0; m_blocked = 0; m_done = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic st, input logic en, input logic br, input logic cma);
    if (!m_busy) begin
      if (m_pend || st) begin
        m_busy = 1; m_in_cmd = 1; m_pend = 0;
      end
    end else begin
      if (st) m_pend = 1;
      if (m_in_cmd) begin
        m_in_cmd = 0;
      end else if (m_owns_bus) begin
        if (en) m_done = 1;
        if (!br) begin
          m_owns_bus = 0;
          if (m_done) begin m_busy = 0; m_done = 0; end
        end
      end else if (m_blocked) begin
        if (!br) m_blocked = 0;
        else if (!cma) begin m_blocked = 0; m_owns_bus = 1; end
      end else if (br) begin
        if (cma) m_blocked = 1;
        else m_owns_bus = 1;
      end else if (en) begin
        m_busy = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic st_r, en_r, br_r, cma_r, req_r;
    logic [31:0] cmd_word;

    // 1. reset with spurious BR, then one command
    reset = 1'b1;
    drive(0, 0, 1, 0, 0);
    tick(); tick();
    check("rst_bg", BG, 0);
    check("rst_cmd", cmd, 0);
    check("rst_busy", dma_busy, 0);
    check("rst_preempt", preempt, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    reset = 1'b0;
    tick();
    check("spurious_br_bg", BG, 0);
    check("spurious_br_busy", dma_busy, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    check("cmd_pulse", cmd, 1);
    check("cmd_addr", cmd_addr, 32'h01F4);
    check("cmd_len", cmd_len, 12);
    check("cmd_busy", dma_busy, 1);
    drive(0, 0, 0, 0, 0);
    tick();
    check("cmd_one_cycle", cmd, 0);
    check("cmd_addr_zero", cmd_addr, 0);
    check("cmd_len_zero", cmd_len, 0);

    // 2. grant latency and completion with BR fall + end pulse together
    drive(0, 0, 1, 0, 0);
    tick();
    check("grant_t1", BG, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("grant_hold", BG, 1);
    end
    drive(0, 1, 0, 0, 0);
    tick();
    check("release_bg", BG, 0);
    check("release_idle", dbg_state, ARB_IDLE);
    check("release_busy", dma_busy, 0);

    // 3. grant waits for the Dcache access to finish
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cache_block_bg", BG, 0);
    end
    drive(0, 0, 1, 0, 0);
    tick();
    check("cache_free_bg", BG, 1);
    cpu_mem_req = 1'b1;
    #1;
    check("cpu_stall_on", cpu_stall, 1);
    cpu_mem_req = 1'b0;
    #1;
    check("cpu_stall_off", cpu_stall, 0);

    // 4. starts during GRANT: one pending command, extra start dropped
    drive(1, 0, 1, 0, 0); tick();
    check("pend_no_cmd_a", cmd, 0);
    drive(0, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    check("pend_return_idle", dbg_state, ARB_IDLE);
    check("pend_no_cmd_b", cmd, 0);
    drive(0, 0, 0, 0, 0); tick();
    check("pend_cmd", cmd, 1);
    check("pend_cmd_addr", cmd_addr, 32'h01F4);
    tick();
    drive(0, 0, 1, 0, 0); tick();
    check("pend_grant", BG, 1);
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_no_third_cmd", cmd, 0);
      check("pend_idle_busy", dma_busy, 0);
    end

    // 5. reset during GRANT discards the pending transfer
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    check("rst_grant_pre", BG, 1);
    drive(1, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0);
    reset = 1'b1;
    tick();
    check("rst_grant_bg", BG, 0);
    check("rst_grant_busy", dma_busy, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_pending_cmd", cmd, 0);
    end

`ifdef BUS_PREEMPT_EN
    // 6. watchdog preemption and one-cycle deferral of a re-raised BR
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 1); tick();
    check("wd_grant", BG, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("wd_preempt", preempt, (i == 16) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 1); tick();
    check("wd_drop_bg", BG, 0);
    check("wd_drop_preempt", preempt, 0);
    drive(0, 0, 1, 0, 1); tick();
    check("wd_deferred", BG, 0);
    tick();
    check("wd_regrant", BG, 1);
    drive(0, 1, 0, 0, 0); tick();
    check("wd_done_idle", dbg_state, ARB_IDLE);
`endif

    // 7. randomized traffic against the reference model
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    br_r = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      st_r  = ($urandom_range(0, 5) == 0);
      en_r  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) br_r = ~br_r;
      cma_r = ($urandom_range(0, 2) == 0);
      req_r = ($urandom_range(0, 3) == 0);
      drive(st_r, en_r, br_r, cma_r, req_r);
      tick();
      model_step(st_r, en_r, br_r, cma_r);
      if (m_in_cmd) exp_q.push_back({16'h01F4, 16'd12});
      check("rnd_cmd", cmd, m_in_cmd);
      check("rnd_bg", BG, m_owns_bus);
      check("rnd_busy", dma_busy, m_busy);
      check("rnd_stall", cpu_stall, req_r & m_owns_bus);
`ifndef BUS_PREEMPT_EN
      check("rnd_preempt", preempt, 0);
`endif
      if (cmd === 1'b1) begin
        check("rnd_cmd_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cmd_word = exp_q.pop_front();
          check("rnd_cmd_word", {cmd_addr, cmd_len}, cmd_word);
        end
      end else begin
        check("rnd_cmd_word_idle", {cmd_addr, cmd_len}, 0);
      end
    end
    check("exp_q_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
